// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared serial bus, with a hold-time watchdog.
// One master owns the bus at a time; a single turnaround cycle separates owners.
module bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int OWNER_W        = 1,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TIMEOUT_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] approval_request,
   input  logic [NUM_MASTERS-1:0] tx_done,
   output logic [NUM_MASTERS-1:0] approval_grant,
   output logic                   busy,
   output logic [OWNER_W-1:0]     bus_owner,
   output logic                   owner_valid,
   output logic                   timeout_flag
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWNED   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [OWNER_W-1:0]       owner_q, owner_d;
   logic [OWNER_W-1:0]       rr_q, rr_d;
   logic [TIMEOUT_W-1:0]     wd_q, wd_d;
   logic                     tflag_q, tflag_d;

   logic [2*NUM_MASTERS-1:0] req_dbl;
   logic [NUM_MASTERS-1:0]   req_rot;
   logic                     found;
   logic [OWNER_W-1:0]       sel;
   logic                     own_done, own_drop, own_timeout;

   // Rotate the requests so bit 0 lines up with the rr pointer; the lowest set bit wins.
   assign req_dbl = {approval_request, approval_request} >> rr_q;
   assign req_rot = req_dbl[NUM_MASTERS-1:0];

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found = 1'b1;
            sel   = OWNER_W'((int'(rr_q) + k) % NUM_MASTERS);
         end
      end
   end

   assign own_done    = tx_done[owner_q];
   assign own_drop    = !approval_request[owner_q];
   assign own_timeout = (TIMEOUT_CYCLES != 0) &&
                        (wd_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      wd_d    = wd_q;
      tflag_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = OWNED;
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               owner_d      = sel;
               wd_d         = '0;
            end
         end
         OWNED: begin
            if (own_done || own_drop || own_timeout) begin
               state_d = RELEASE;
               grant_d = '0;
               // The flag marks a forced release only; a clean finish on the last cycle is normal.
               tflag_d = own_timeout && !own_done && !own_drop;
               rr_d    = (owner_q == OWNER_W'(NUM_MASTERS - 1)) ? '0
                                                                : owner_q + OWNER_W'(1);
            end else begin
               wd_d = wd_q + TIMEOUT_W'(1);
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         wd_q    <= '0;
         tflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         wd_q    <= wd_d;
         tflag_q <= tflag_d;
      end
   end

   assign approval_grant = grant_q;
   assign busy           = (state_q != IDLE);
   assign owner_valid    = (state_q == OWNED);
   assign bus_owner      = owner_q;
   assign timeout_flag   = tflag_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a vector table on a 2-master instance, hand sequences and a
// randomized run checked against a reference model on a 3-master instance.
module tb_bus_arbiter;
   localparam int N3 = 3;
   localparam int T3 = 6;

   logic       clk;
   logic       rst2_n, rst3_n;
   logic [1:0] req2, done2, grant2;
   logic       busy2, valid2, tf2;
   logic [0:0] owner2;
   logic [2:0] req3, done3, grant3;
   logic       busy3, valid3, tf3;
   logic [1:0] owner3;

   int n_checks = 0;
   int n_err    = 0;

   bus_arbiter #(.NUM_MASTERS(2), .OWNER_W(1), .TIMEOUT_CYCLES(8), .TIMEOUT_W(16)) dut2 (
      .clk(clk), .reset(rst2_n), .approval_request(req2), .tx_done(done2),
      .approval_grant(grant2), .busy(busy2), .bus_owner(owner2),
      .owner_valid(valid2), .timeout_flag(tf2)
   );

   bus_arbiter #(.NUM_MASTERS(N3), .OWNER_W(2), .TIMEOUT_CYCLES(T3), .TIMEOUT_W(8)) dut3 (
      .clk(clk), .reset(rst3_n), .approval_request(req3), .tx_done(done3),
      .approval_grant(grant3), .busy(busy3), .bus_owner(owner3),
      .owner_valid(valid3), .timeout_flag(tf3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [1:0] req;
      logic [1:0] done;
      logic [1:0] grant;
      logic       busy;
      logic       owner;
      logic       valid;
      logic       tflag;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, logic [1:0] req, logic [1:0] done, logic [1:0] grant,
                               logic busy, logic owner, logic valid, logic tflag);
      vec_t v;
      v.rst = rst; v.req = req; v.done = done; v.grant = grant;
      v.busy = busy; v.owner = owner; v.valid = valid; v.tflag = tflag;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] out3();
      return 16'({grant3, busy3, owner3, valid3, tf3});
   endfunction

   task automatic step3(input string name, input logic [2:0] req, input logic [2:0] done,
                        input logic [7:0] exp);
      req3  = req;
      done3 = done;
      @(posedge clk); #1;
      check(name, out3(), 16'(exp));
   endtask

   // reference model: owner as an index, hold time as a plain count of granted edges
   int m_owner, m_last, m_turn, m_rr, m_held, m_flag;

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_turn = 0; m_rr = 0; m_held = 0; m_flag = 0;
   endtask

   task automatic model_step(input logic [2:0] req, input logic [2:0] done);
      bit fin, drop, tmo, hit;
      m_flag = 0;
      if (m_owner >= 0) begin
         m_held++;
         fin  = done[m_owner];
         drop = !req[m_owner];
         tmo  = (T3 != 0) && (m_held == T3);
         if (fin || drop || tmo) begin
            m_flag  = (tmo && !fin && !drop) ? 1 : 0;
            m_rr    = (m_owner + 1) % N3;
            m_owner = -1;
            m_turn  = 1;
         end
      end else if (m_turn != 0) begin
         m_turn = 0;
      end else begin
         hit = 1'b0;
         for (int k = 0; k < N3; k++) begin
            int idx;
            idx = (m_rr + k) % N3;
            if (!hit && req[idx]) begin
               hit = 1'b1;
               m_owner = idx;
               m_last  = idx;
               m_held  = 0;
            end
         end
      end
   endtask

   function automatic logic [15:0] model_out();
      logic [2:0] g;
      logic [2:0] one;
      one = 3'b001;
      g = (m_owner >= 0) ? (one << m_owner) : 3'b000;
      return 16'({g, ((m_owner >= 0) || (m_turn != 0)) ? 1'b1 : 1'b0, 2'(m_last),
                  (m_owner >= 0) ? 1'b1 : 1'b0, (m_flag != 0) ? 1'b1 : 1'b0});
   endfunction

   initial begin
      rst2_n = 1'b0; rst3_n = 1'b0;
      req2 = '0; done2 = '0; req3 = '0; done3 = '0;

      // idle, then single owner finishing with tx_done
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 1, 0, 1, 0));
      tbl.push_back(mk(0, 2'b01, 2'b01, 2'b00, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      // reset, then contention with a non-owner tx_done and a pending re-request
      tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 0, 1, 0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 0, 1, 0));
      tbl.push_back(mk(0, 2'b11, 2'b01, 2'b00, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b10, 1, 1, 1, 0));
      tbl.push_back(mk(0, 2'b11, 2'b01, 2'b10, 1, 1, 1, 0));
      tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 0, 1, 0));
      // master 1 tx_done ignored, then master 0 withdraws
      tbl.push_back(mk(0, 2'b01, 2'b10, 2'b01, 1, 0, 1, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      // watchdog: 8 held cycles, flagged release
      for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 2'b10, 2'b00, 2'b10, 1, 1, 1, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 1, 1, 0, 1));
      tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0));
      // tx_done on the timeout cycle: normal release, no flag
      for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 2'b10, 2'b00, 2'b10, 1, 1, 1, 0));
      tbl.push_back(mk(0, 2'b10, 2'b10, 2'b00, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));

      #2;
      check("reset2_async", 16'({grant2, busy2, owner2, valid2, tf2}), 16'h0000);
      check("reset3_async", out3(), 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      check("reset2_held", 16'({grant2, busy2, owner2, valid2, tf2}), 16'h0000);

      foreach (tbl[i]) begin
         rst2_n = !tbl[i].rst;
         req2   = tbl[i].req;
         done2  = tbl[i].done;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), 16'({grant2, busy2, owner2, valid2, tf2}),
               16'({tbl[i].grant, tbl[i].busy, tbl[i].owner, tbl[i].valid, tbl[i].tflag}));
      end

      // owner 2 releases, rr wraps to 0, master 0 wins over master 2
      rst3_n = 1'b1;
      step3("wrap_grant2", 3'b100, 3'b000, {3'b100, 1'b1, 2'd2, 1'b1, 1'b0});
      step3("wrap_rel",    3'b101, 3'b100, {3'b000, 1'b1, 2'd2, 1'b0, 1'b0});
      step3("wrap_turn",   3'b101, 3'b000, {3'b000, 1'b0, 2'd2, 1'b0, 1'b0});
      step3("wrap_grant0", 3'b101, 3'b000, {3'b001, 1'b1, 2'd0, 1'b1, 1'b0});
      step3("wrap_hold",   3'b101, 3'b000, {3'b001, 1'b1, 2'd0, 1'b1, 1'b0});
      // reset mid-transaction between edges
      #3 rst3_n = 1'b0;
      #1 check("midop_reset_async", out3(), 16'h0000);
      @(posedge clk); #1;
      check("midop_reset_held", out3(), 16'h0000);
      // search from rr=2 wraps past the top to master 0
      rst3_n = 1'b1;
      step3("srch_grant1", 3'b010, 3'b000, {3'b010, 1'b1, 2'd1, 1'b1, 1'b0});
      step3("srch_rel",    3'b010, 3'b010, {3'b000, 1'b1, 2'd1, 1'b0, 1'b0});
      step3("srch_turn",   3'b001, 3'b000, {3'b000, 1'b0, 2'd1, 1'b0, 1'b0});
      step3("srch_grant0", 3'b001, 3'b000, {3'b001, 1'b1, 2'd0, 1'b1, 1'b0});
      step3("srch_drop",   3'b000, 3'b000, {3'b000, 1'b1, 2'd0, 1'b0, 1'b0});
      step3("srch_idle",   3'b000, 3'b000, {3'b000, 1'b0, 2'd0, 1'b0, 1'b0});

      // randomized run against the model
      rst3_n = 1'b0;
      req3 = '0; done3 = '0;
      model_reset();
      @(posedge clk); #1;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N3; b++)
            if ($urandom_range(0, 5) == 0) req3[b] = ~req3[b];
         done3 = 3'b000;
         if ($urandom_range(0, 7) == 0) done3[$urandom_range(0, 2)] = 1'b1;
         if ($urandom_range(0, 149) == 0) begin
            rst3_n = 1'b0;
            model_reset();
         end else begin
            rst3_n = 1'b1;
            model_step(req3, done3);
         end
         @(posedge clk); #1;
         check($sformatf("rand%0d", c), out3(), model_out());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
